// File: rtl/piece_write_buffer.sv
// rtl/piece_write_buffer.sv - falling-piece overlay with spawn, rotate, gravity shift and hold/swap slot
module piece_write_buffer #(
  parameter int         COLS       = 10,
  parameter int         ROWS       = 22,
  parameter int         SPAWN_ROWS = 2,
  parameter logic [7:0] KEY_ROTATE = 8'h1A,
  parameter logic [7:0] KEY_SWAP   = 8'h06
) (
  input  logic                       Clk,
  input  logic                       Reset_h,
  input  logic                       spawn,
  input  logic                       lock,
  input  logic                       shift_down,
  input  logic [7:0]                 keycode,
  input  logic                       can_rotate,
  input  logic                       can_swap,
  input  logic [SPAWN_ROWS*COLS-1:0] new_block,
  input  logic [ROWS*COLS-1:0]       next_rotation,
  output logic [ROWS*COLS-1:0]       next_write,
  output logic [SPAWN_ROWS*COLS-1:0] hold_block,
  output logic                       hold_valid,
  output logic                       swap_used,
  output logic                       next_req,
  output logic                       piece_active
);

  localparam int W  = ROWS * COLS;
  localparam int SW = SPAWN_ROWS * COLS;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] cur_spawn;
  logic [7:0]    key_prev;
  logic          rot_evt;
  logic          swap_evt;

  // A held key only acts on the cycle it first appears.
  assign rot_evt  = (keycode == KEY_ROTATE) && (key_prev != KEY_ROTATE);
  assign swap_evt = (keycode == KEY_SWAP) && (key_prev != KEY_SWAP);

  assign piece_active = (state == ST_ACTIVE);

  // Places a spawn-orientation piece (element 0 = top row) at the top of an otherwise empty overlay.
  function automatic logic [W-1:0] load_top(input logic [SW-1:0] blk);
    logic [W-1:0] ov;
    ov = '0;
    for (int i = 0; i < SPAWN_ROWS; i++) begin
      ov[(ROWS-1-i)*COLS +: COLS] = blk[i*COLS +: COLS];
    end
    return ov;
  endfunction

  // Keycode history, sampled every cycle regardless of state.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      key_prev <= 8'h00;
    end else begin
      key_prev <= keycode;
    end
  end

  // Single prioritised action per cycle: spawn > lock > swap > rotate > shift.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state      <= ST_EMPTY;
      next_write <= '0;
      cur_spawn  <= '0;
      hold_block <= '0;
      hold_valid <= 1'b0;
      swap_used  <= 1'b0;
      next_req   <= 1'b0;
    end else begin
      next_req <= 1'b0;
      if (spawn) begin
        next_write <= load_top(new_block);
        cur_spawn  <= new_block;
        next_req   <= 1'b1;
        swap_used  <= 1'b0;
        state      <= ST_ACTIVE;
      end else if (state == ST_ACTIVE) begin
        if (lock) begin
          next_write <= '0;
          swap_used  <= 1'b0;
          state      <= ST_EMPTY;
        end else if (swap_evt) begin
          if (can_swap && !swap_used) begin
            swap_used  <= 1'b1;
            hold_block <= cur_spawn;
            hold_valid <= 1'b1;
            if (hold_valid) begin
              next_write <= load_top(hold_block);
              cur_spawn  <= hold_block;
            end else begin
              next_write <= load_top(new_block);
              cur_spawn  <= new_block;
              next_req   <= 1'b1;
            end
          end
        end else if (rot_evt) begin
          if (can_rotate) begin
            next_write <= next_rotation;
          end
        end else if (shift_down) begin
          next_write <= next_write >> COLS;
        end
      end
    end
  end

endmodule
